// File: rtl/ram_responder_pkg.sv
// Shared definitions for the RAM word-bus responder: FSM encodings and wait-counter sizing.
package ram_responder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle    = 2'd0;
  localparam state_t StWait    = 2'd1;
  localparam state_t StAck     = 2'd2;
  localparam state_t StRefresh = 2'd3;

  localparam int unsigned WaitCntWidth = 4;

  typedef logic [WaitCntWidth-1:0] wait_cnt_t;

  // Wait states to insert for an access of the given direction.
  function automatic wait_cnt_t wait_load(input logic is_write, input int unsigned rd_wait,
                                          input int unsigned wr_wait);
    return is_write ? wait_cnt_t'(wr_wait) : wait_cnt_t'(rd_wait);
  endfunction

endpackage

// File: rtl/ram_responder_mem.sv
// Synchronous 32-bit word array: one write port, one registered read port (cleared by reset).
module ram_responder_mem #(
  parameter int unsigned AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [2**AW];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (rd_en) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ram_responder.sv
// Target side of the 32-bit RAM word bus with programmable wait states and a single-cycle ack.
// Optional refresh bursts are enabled by defining RAMRESP_REFRESH_EN.
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 23,
  parameter int unsigned MEM_AW      = 16,
  parameter int unsigned RD_WAIT     = 2,
  parameter int unsigned WR_WAIT     = 1,
  parameter int unsigned RFSH_PERIOD = 256,
  parameter int unsigned RFSH_LEN    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stb,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  output logic                  ack,
  output logic                  rfsh
);

  state_t      state_q, state_d;
  wait_cnt_t   cnt_q, cnt_d;
  logic        we_q;
  logic [MEM_AW-1:0] addr_q;
  logic [31:0] wdata_q;
  logic        latch;
  logic        mem_wr, mem_rd;
  logic        rfsh_go, rfsh_done;

  // Upper address bits alias onto the implemented array.
  logic unused_addr;
  assign unused_addr = ^addr;

`ifdef RAMRESP_REFRESH_EN
  localparam int unsigned PerW = (RFSH_PERIOD > 1) ? $clog2(RFSH_PERIOD) : 1;
  localparam int unsigned LenW = $clog2(RFSH_LEN + 1);

  logic [PerW-1:0] per_q;
  logic [LenW-1:0] len_q;
  logic            pend_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      per_q  <= '0;
      pend_q <= 1'b0;
      len_q  <= '0;
    end else begin
      per_q <= (per_q == PerW'(RFSH_PERIOD - 1)) ? '0 : per_q + 1'b1;
      if (per_q == PerW'(RFSH_PERIOD - 1)) begin
        pend_q <= 1'b1;
      end else if (rfsh_go) begin
        pend_q <= 1'b0;
      end
      if (rfsh_go) begin
        len_q <= LenW'(RFSH_LEN - 1);
      end else if (len_q != '0) begin
        len_q <= len_q - 1'b1;
      end
    end
  end

  // Refresh only starts from idle so an in-flight access always completes first.
  assign rfsh_go   = (state_q == StIdle) && pend_q;
  assign rfsh_done = (len_q == '0);
`else
  logic unused_rfsh_cfg;
  assign unused_rfsh_cfg = ^{RFSH_PERIOD, RFSH_LEN};
  assign rfsh_go   = 1'b0;
  assign rfsh_done = 1'b1;
`endif

  // The first wait cycle always elapses so the latched address can reach the array;
  // cnt counts the programmed wait states on top of that.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    mem_wr  = 1'b0;
    mem_rd  = 1'b0;
    case (state_q)
      StIdle: begin
        if (rfsh_go) begin
          state_d = StRefresh;
        end else if (stb) begin
          latch   = 1'b1;
          cnt_d   = wait_load(we, RD_WAIT, WR_WAIT);
          state_d = StWait;
        end
      end
      StWait: begin
        if (!stb) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = StAck;
          mem_wr  = we_q;
          mem_rd  = !we_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      StRefresh: begin
        if (rfsh_done) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch) begin
        we_q    <= we;
        addr_q  <= addr[MEM_AW-1:0];
        wdata_q <= data_in;
      end
    end
  end

  ram_responder_mem #(
    .AW(MEM_AW)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .wr_en(mem_wr && !rst),
    .rd_en(mem_rd),
    .addr (addr_q),
    .wdata(wdata_q),
    .rdata(data_out)
  );

  assign ack  = (state_q == StAck);
  assign rfsh = (state_q == StRefresh);

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: latency, back-to-back, abort, reset, aliasing and refresh.
module tb_ram_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [22:0] addr = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        ack;
  logic        rfsh;

  int passed = 0;
  int total  = 0;

  ram_responder #(
    .ADDR_WIDTH (23),
    .MEM_AW     (16),
    .RD_WAIT    (2),
    .WR_WAIT    (1),
    .RFSH_PERIOD(16),
    .RFSH_LEN   (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .stb     (stb),
    .we      (we),
    .addr    (addr),
    .data_in (data_in),
    .data_out(data_out),
    .ack     (ack),
    .rfsh    (rfsh)
  );

  always #5 clk = ~clk;

  // Counts cycles from the current one until ack is seen; -1 on timeout.
  task automatic wait_ack(output int n, output logic [31:0] q);
    n = 0;
    q = '0;
    @(negedge clk);
    while (!ack && n >= 0) begin
      n++;
      if (n > 40) n = -1;
      else @(negedge clk);
    end
    q = data_out;
  endtask

  // Lets a pending refresh burst finish so a short access runs undisturbed.
  task automatic quiet();
`ifdef RAMRESP_REFRESH_EN
    int n;
    n = 0;
    @(negedge clk);
    while (!rfsh && n < 40) begin
      @(negedge clk);
      n++;
    end
    while (rfsh && n < 80) begin
      @(negedge clk);
      n++;
    end
`endif
  endtask

  task automatic access(input logic w, input logic [22:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] q);
    quiet();
    @(posedge clk);
    #1;
    stb = 1'b1;
    we = w;
    addr = a;
    data_in = d;
    wait_ack(lat, q);
    @(posedge clk);
    #1;
    stb = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", ack); else passed++;
    total++;
    if (data_out !== 32'h0) $display("FAIL reset_data: got %h want 00000000", data_out);
    else passed++;
    total++;
    if (rfsh !== 1'b0) $display("FAIL reset_rfsh: got %b want 0", rfsh); else passed++;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (ack) n++;
    end
    total++;
    if (n !== 0) $display("FAIL idle_no_ack: got %0d acks want 0", n); else passed++;
  endtask

  task automatic test_write_read();
    int lat;
    logic [31:0] q;
    access(1'b1, 23'h000010, 32'hDEADBEEF, lat, q);
    total++;
    if (lat !== 3) $display("FAIL wr_latency: got %0d want 3", lat); else passed++;
    @(negedge clk);
    total++;
    if (ack !== 1'b0) $display("FAIL ack_one_cycle: got %b want 0", ack); else passed++;
    access(1'b0, 23'h000010, 32'h0, lat, q);
    total++;
    if (lat !== 4) $display("FAIL rd_latency: got %0d want 4", lat); else passed++;
    total++;
    if (q !== 32'hDEADBEEF) $display("FAIL rd_data: got %h want deadbeef", q); else passed++;
    repeat (3) @(negedge clk);
    total++;
    if (data_out !== 32'hDEADBEEF) $display("FAIL rd_hold: got %h want deadbeef", data_out);
    else passed++;
    access(1'b1, 23'h000011, 32'h12345678, lat, q);
    @(negedge clk);
    total++;
    if (data_out !== 32'hDEADBEEF) $display("FAIL wr_keeps_dout: got %h want deadbeef", data_out);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] q;
    access(1'b1, 23'h000020, 32'hA0A0A020, lat, q);
    access(1'b1, 23'h000021, 32'hB1B1B121, lat, q);
    quiet();
    @(posedge clk);
    #1;
    stb = 1'b1;
    we = 1'b0;
    addr = 23'h000020;
    wait_ack(lat, q);
    total++;
    if (lat !== 4) $display("FAIL b2b_lat0: got %0d want 4", lat); else passed++;
    total++;
    if (q !== 32'hA0A0A020) $display("FAIL b2b_data0: got %h want a0a0a020", q); else passed++;
    @(posedge clk);
    #1;
    addr = 23'h000021;
    wait_ack(lat, q);
    total++;
    if (lat !== 4) $display("FAIL b2b_lat1: got %0d want 4", lat); else passed++;
    total++;
    if (q !== 32'hB1B1B121) $display("FAIL b2b_data1: got %h want b1b1b121", q); else passed++;
    @(posedge clk);
    #1;
    stb = 1'b0;
  endtask

  task automatic test_abort();
    int lat;
    int n;
    logic [31:0] q;
    access(1'b1, 23'h000030, 32'hCAFEF00D, lat, q);
    quiet();
    @(posedge clk);
    #1;
    stb = 1'b1;
    we = 1'b1;
    addr = 23'h000030;
    data_in = 32'h5A5A5A5A;
    @(posedge clk);
    #1;
    stb = 1'b0;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack) n++;
    end
    total++;
    if (n !== 0) $display("FAIL abort_no_ack: got %0d acks want 0", n); else passed++;
    access(1'b0, 23'h000030, 32'h0, lat, q);
    total++;
    if (q !== 32'hCAFEF00D) $display("FAIL abort_no_write: got %h want cafef00d", q);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [31:0] q;
    access(1'b1, 23'h000040, 32'h0BADF00D, lat, q);
    access(1'b0, 23'h000040, 32'h0, lat, q);
    quiet();
    @(posedge clk);
    #1;
    stb = 1'b1;
    we = 1'b1;
    addr = 23'h000040;
    data_in = 32'h77777777;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    stb = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (ack !== 1'b0) $display("FAIL rstmid_ack: got %b want 0", ack); else passed++;
    total++;
    if (data_out !== 32'h0) $display("FAIL rstmid_data: got %h want 00000000", data_out);
    else passed++;
    access(1'b0, 23'h000040, 32'h0, lat, q);
    total++;
    if (q !== 32'h0BADF00D) $display("FAIL rstmid_discard: got %h want 0badf00d", q);
    else passed++;
  endtask

  task automatic test_alias();
    int lat;
    logic [31:0] q;
    access(1'b1, 23'h010005, 32'h11111111, lat, q);
    access(1'b0, 23'h000005, 32'h0, lat, q);
    total++;
    if (q !== 32'h11111111) $display("FAIL alias_lo: got %h want 11111111", q); else passed++;
    access(1'b1, 23'h000006, 32'h22222222, lat, q);
    access(1'b0, 23'h7F0006, 32'h0, lat, q);
    total++;
    if (q !== 32'h22222222) $display("FAIL alias_hi: got %h want 22222222", q); else passed++;
  endtask

`ifdef RAMRESP_REFRESH_EN
  task automatic test_refresh();
    int n;
    int rc;
    n = 0;
    @(negedge clk);
    while (!rfsh && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!rfsh) $display("FAIL rfsh_seen: got 0 want 1 within 40 cycles");
    else passed++;
    // Request raised in the first refresh cycle: 4 refresh cycles, then the normal 4-cycle read.
    stb = 1'b1;
    we = 1'b0;
    addr = 23'h000010;
    n = 0;
    rc = 1;
    @(negedge clk);
    while (!ack && n < 40) begin
      n++;
      if (rfsh) rc++;
      @(negedge clk);
    end
    n++;
    total++;
    if (rc !== 4) $display("FAIL rfsh_len: got %0d want 4", rc); else passed++;
    total++;
    if (n !== 8) $display("FAIL rfsh_ack_delay: got %0d want 8", n); else passed++;
    total++;
    if (data_out !== 32'hDEADBEEF) $display("FAIL rfsh_data: got %h want deadbeef", data_out);
    else passed++;
    @(posedge clk);
    #1;
    stb = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_alias();
`ifdef RAMRESP_REFRESH_EN
    test_refresh();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
